// File: rtl/fixed_packer_if.sv
// Valid/ready handshake bundle for the fixed-to-float packer.
// The slave modport is the packer's view; the master modport is the environment's view.
interface fixed_packer_if;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] in_fixed;
  logic               out_valid;
  logic               out_ready;
  logic        [31:0] out_float;

  modport slave (
    input  in_valid, in_fixed, out_ready,
    output in_ready, out_valid, out_float
  );

  modport master (
    output in_valid, in_fixed, out_ready,
    input  in_ready, out_valid, out_float
  );
endinterface

// File: rtl/fixed_packer.sv
// Sequential signed Q2.30 to IEEE-754 single packer with round-to-nearest-even.
// Define PACKER_FAST_NORM_EN for a single-cycle barrel-shift normalizer.
module fixed_packer #(
  parameter int FRAC_BITS = 30
) (
  input  logic          clk,
  input  logic          rst_n,
  fixed_packer_if.slave bus,
  output logic          busy
);

  localparam int         DATA_W   = 32;
  localparam logic [7:0] EXP_INIT = 8'(127 + 31 - FRAC_BITS);

  typedef enum logic [2:0] {IDLE, ABS, NORM, ROUND, DONE} state_t;

  state_t                   state, state_nxt;
  logic signed [DATA_W-1:0] fix_r;
  logic                     sign_r;
  logic        [DATA_W-1:0] mag_r;
  logic        [DATA_W-1:0] abs_mag;
  logic        [7:0]        exp_r;
  logic        [DATA_W-1:0] float_r;

  // Round the normalized magnitude (bit 31 set) and assemble the float word.
  function automatic logic [31:0] pack_rne(input logic s, input logic [31:0] m,
                                           input logic [7:0] e);
    logic [23:0] mant;
    logic        guard;
    logic        sticky;
    logic [7:0]  e_out;
    guard  = m[7];
    sticky = |m[6:0];
    mant   = {1'b0, m[30:8]} + 24'(guard && (sticky || m[8]));
    e_out  = e;
    if (mant[23]) begin
      mant  = 24'd0;
      e_out = e + 8'd1;
    end
    return {s, e_out, mant[22:0]};
  endfunction

`ifdef PACKER_FAST_NORM_EN
  function automatic logic [4:0] count_lz(input logic [31:0] m);
    logic [4:0] lz;
    lz = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (m[i]) lz = 5'(31 - i);
    end
    return lz;
  endfunction

  logic [4:0] lz;
  assign lz = count_lz(mag_r);
`endif

  // -0x80000000 wraps back to 0x80000000, which is the correct magnitude.
  assign abs_mag = fix_r[DATA_W-1] ? $unsigned(-fix_r) : $unsigned(fix_r);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.in_valid) state_nxt = ABS;
      ABS:   state_nxt = (fix_r == '0) ? DONE : NORM;
`ifdef PACKER_FAST_NORM_EN
      NORM:  state_nxt = ROUND;
`else
      NORM:  if (mag_r[DATA_W-1]) state_nxt = ROUND;
`endif
      ROUND: state_nxt = DONE;
      DONE:  if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_float = float_r;
  assign busy          = (state != IDLE);

  // Capture, absolute value and normalization
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (bus.in_valid) fix_r <= bus.in_fixed;
      ABS: begin
        sign_r <= fix_r[DATA_W-1];
        mag_r  <= abs_mag;
        exp_r  <= EXP_INIT;
      end
`ifdef PACKER_FAST_NORM_EN
      NORM: begin
        mag_r <= mag_r << lz;
        exp_r <= exp_r - 8'(lz);
      end
`else
      NORM: if (!mag_r[DATA_W-1]) begin
        mag_r <= mag_r << 1;
        exp_r <= exp_r - 8'd1;
      end
`endif
      default: ;
    endcase
  end

  // Result register: zero short-circuits in ABS, everything else in ROUND
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      float_r <= '0;
    end else if (state == ABS && fix_r == '0) begin
      float_r <= '0;
    end else if (state == ROUND) begin
      float_r <= pack_rne(sign_r, mag_r, exp_r);
    end
  end

endmodule

// File: tb/tb_fixed_packer.sv
// Self-checking bench for fixed_packer: directed corner cases plus random values
// compared against an arithmetic reference model.
module tb_fixed_packer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  fixed_packer_if bus ();

  fixed_packer #(.FRAC_BITS(30)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Value = v / 2^30; round the exact binary fraction to a 24-bit significand.
  function automatic logic [31:0] model_float(input logic [31:0] v);
    logic [63:0] a, q, rem, half, v64;
    int          p, e;
    logic        s;
    if (v == 32'd0) return 32'd0;
    s   = v[31];
    v64 = {32'd0, v};
    a   = s ? (64'h1_0000_0000 - v64) : v64;
    p   = 0;
    while ((64'd1 << (p + 1)) <= a) p++;
    e = 127 + p - 30;
    if (p > 23) begin
      q    = a >> (p - 23);
      rem  = a - (q << (p - 23));
      half = 64'd1 << (p - 24);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
    end else begin
      q = a << (23 - p);
    end
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e++;
    end
    return {s, 8'(e), q[22:0]};
  endfunction

  function automatic int model_latency(input logic [31:0] v);
    logic [63:0] a, v64;
    int          p;
    if (v == 32'd0) return 1;
`ifdef PACKER_FAST_NORM_EN
    return 3;
`else
    v64 = {32'd0, v};
    a   = v[31] ? (64'h1_0000_0000 - v64) : v64;
    p   = 0;
    while ((64'd1 << (p + 1)) <= a) p++;
    return (31 - p) + 3;
`endif
  endfunction

  // Offer one value, measure latency to out_valid, then complete the handshake.
  task automatic convert(input logic [31:0] val, input bit early_rdy,
                         output logic [31:0] res, output int n);
    @(negedge clk);
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_fixed  = val;
    bus.out_ready = early_rdy;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.out_valid) break;
    end
    res = bus.out_float;
    check("out_valid_timeout", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("out_valid_drop", 32'(bus.out_valid), 32'd0);
    check("out_float_hold", bus.out_float, res);
    bus.out_ready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] val;
    logic [31:0] expf;
    int          lat;
  } vec_t;

  initial begin
    vec_t        vecs[7];
    logic [31:0] res, held, v;
    int          n;

    bus.in_valid  = 1'b0;
    bus.in_fixed  = '0;
    bus.out_ready = 1'b0;

    // Reset values
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_float", bus.out_float, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors with latencies for the iterative build
    vecs[0] = '{32'h40000000, 32'h3F800000, 4};
    vecs[1] = '{32'hC0000000, 32'hBF800000, 4};
    vecs[2] = '{32'h26DD3B80, 32'h3F1B74EE, 5};
    vecs[3] = '{32'h80000000, 32'hC0000000, 3};
    vecs[4] = '{32'h7FFFFFFF, 32'h40000000, 4};
    vecs[5] = '{32'h00000001, 32'h30800000, 34};
    vecs[6] = '{32'h00000000, 32'h00000000, 1};
    foreach (vecs[i]) begin
      convert(vecs[i].val, 1'b0, res, n);
      check($sformatf("dir_float_%h", vecs[i].val), res, vecs[i].expf);
`ifdef PACKER_FAST_NORM_EN
      check($sformatf("dir_lat_%h", vecs[i].val), 32'(n), (vecs[i].val == 0) ? 32'd1 : 32'd3);
`else
      check($sformatf("dir_lat_%h", vecs[i].val), 32'(n), 32'(vecs[i].lat));
`endif
    end

    // Backpressure with an ignored input pulse while busy
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_fixed = 32'h40000000;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    held = bus.out_float;
    check("bp_float", held, 32'h3F800000);
    for (int c = 0; c < 10; c++) begin
      if (c == 4) begin
        bus.in_valid = 1'b1;
        bus.in_fixed = 32'h12345678;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      check("bp_valid", 32'(bus.out_valid), 32'd1);
      check("bp_stable", bus.out_float, held);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("bp_release_valid", 32'(bus.out_valid), 32'd0);
    check("bp_release_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    check("bp_no_accept", 32'(busy), 32'd0);

    // Reset in the middle of normalization
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_fixed = 32'h00000001;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("mid_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_out_float", bus.out_float, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    convert(32'h40000000, 1'b0, res, n);
    check("post_rst_float", res, 32'h3F800000);

    // Random values against the reference model
    for (int i = 0; i < 40; i++) begin
      v = $urandom;
      if (i % 3 == 1) v = v >> $urandom_range(31, 0);
      if (i % 3 == 2) v = -(v >> $urandom_range(31, 1));
      convert(v, 1'($urandom_range(1, 0)), res, n);
      check($sformatf("rnd_float_%h", v), res, model_float(v));
      check($sformatf("rnd_lat_%h", v), 32'(n), 32'(model_latency(v)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
